// File: rtl/ram32_access_arbiter.sv
// Shares one RAM32 macro between the SERV ibus, the SERV dbus and the host byte port.
// Each access is IDLE (arbitrate) -> CMD (macro enabled) -> ACK (Do0 returned), so acks are >= 3 cycles apart.
module ram32_access_arbiter #(
    parameter int RAM_AW   = 5,
    parameter bit RR_EN    = 1'b1,
    parameter bit HOST_PRI = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ibus_cyc,
    input  logic [31:0]       ibus_adr,
    output logic [31:0]       ibus_rdt,
    output logic              ibus_ack,
    input  logic              dbus_cyc,
    input  logic              dbus_we,
    input  logic [31:0]       dbus_adr,
    input  logic [31:0]       dbus_dat,
    input  logic [3:0]        dbus_sel,
    output logic [31:0]       dbus_rdt,
    output logic              dbus_ack,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [6:0]        host_addr,
    input  logic [7:0]        host_wdata,
    output logic [7:0]        host_rdata,
    output logic              host_ack,
    output logic              ram_en,
    output logic [RAM_AW-1:0] ram_a,
    output logic [3:0]        ram_we,
    output logic [31:0]       ram_di,
    input  logic [31:0]       ram_do
);
    typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, ACK = 2'd2} state_t;
    localparam logic [1:0] G_IBUS = 2'd0;
    localparam logic [1:0] G_DBUS = 2'd1;
    localparam logic [1:0] G_HOST = 2'd2;

    state_t            state_q;
    logic [1:0]        gnt_q, gnt_d, serv_gnt;
    logic              rr_ibus_q;
    logic              oor_q, oor_d;
    logic [1:0]        lane_q;
    logic              host_rd_q;
    logic              ram_en_q, ram_en_d;
    logic [RAM_AW-1:0] ram_a_q, ram_a_d;
    logic [3:0]        ram_we_q, ram_we_d;
    logic [31:0]       ram_di_q, ram_di_d;
    logic              ibus_ack_q, dbus_ack_q, host_ack_q;
    logic [7:0]        host_rdata_q;
    logic              ibus_oor, dbus_oor, serv_vld, any_req;
    logic              unused_adr_bits;

    assign ibus_oor        = |ibus_adr[31:RAM_AW+2];
    assign dbus_oor        = |dbus_adr[31:RAM_AW+2];
    assign serv_vld        = ibus_cyc | dbus_cyc;
    assign any_req         = serv_vld | host_req;
    assign unused_adr_bits = ^{ibus_adr[1:0], dbus_adr[1:0]};

    // rr_ibus_q set means ibus wins the next ibus/dbus tie
    always_comb begin
        serv_gnt = G_IBUS;
        if (ibus_cyc && dbus_cyc) begin
            serv_gnt = (RR_EN && rr_ibus_q) ? G_IBUS : G_DBUS;
        end else if (dbus_cyc) begin
            serv_gnt = G_DBUS;
        end
        if (HOST_PRI) begin
            gnt_d = host_req ? G_HOST : serv_gnt;
        end else begin
            gnt_d = serv_vld ? serv_gnt : G_HOST;
        end
    end

    always_comb begin
        ram_en_d = 1'b0;
        ram_a_d  = '0;
        ram_we_d = 4'b0000;
        ram_di_d = 32'h0;
        oor_d    = 1'b0;
        case (gnt_d)
            G_HOST: begin
                ram_en_d = 1'b1;
                ram_a_d  = RAM_AW'(host_addr[6:2]);
                if (host_we) begin
                    ram_we_d = 4'b0001 << host_addr[1:0];
                    ram_di_d = {4{host_wdata}};
                end
            end
            G_DBUS: begin
                oor_d = dbus_oor;
                if (!dbus_oor) begin
                    ram_en_d = 1'b1;
                    ram_a_d  = dbus_adr[RAM_AW+1:2];
                    if (dbus_we) begin
                        ram_we_d = dbus_sel;
                        ram_di_d = dbus_dat;
                    end
                end
            end
            default: begin
                oor_d = ibus_oor;
                if (!ibus_oor) begin
                    ram_en_d = 1'b1;
                    ram_a_d  = ibus_adr[RAM_AW+1:2];
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            gnt_q        <= G_IBUS;
            rr_ibus_q    <= 1'b1;
            oor_q        <= 1'b0;
            lane_q       <= 2'd0;
            host_rd_q    <= 1'b0;
            ram_en_q     <= 1'b0;
            ram_a_q      <= '0;
            ram_we_q     <= 4'b0000;
            ram_di_q     <= 32'h0;
            ibus_ack_q   <= 1'b0;
            dbus_ack_q   <= 1'b0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q   <= CMD;
                        gnt_q     <= gnt_d;
                        ram_en_q  <= ram_en_d;
                        ram_a_q   <= ram_a_d;
                        ram_we_q  <= ram_we_d;
                        ram_di_q  <= ram_di_d;
                        oor_q     <= oor_d;
                        lane_q    <= host_addr[1:0];
                        host_rd_q <= !host_we;
                    end
                end
                CMD: begin
                    state_q    <= ACK;
                    ram_en_q   <= 1'b0;
                    ram_a_q    <= '0;
                    ram_we_q   <= 4'b0000;
                    ram_di_q   <= 32'h0;
                    ibus_ack_q <= (gnt_q == G_IBUS);
                    dbus_ack_q <= (gnt_q == G_DBUS);
                    host_ack_q <= (gnt_q == G_HOST);
                end
                ACK: begin
                    state_q    <= IDLE;
                    ibus_ack_q <= 1'b0;
                    dbus_ack_q <= 1'b0;
                    host_ack_q <= 1'b0;
                    if (host_ack_q && host_rd_q) begin
                        host_rdata_q <= ram_do[8*lane_q +: 8];
                    end
                    if (ibus_ack_q) begin
                        rr_ibus_q <= 1'b0;
                    end
                    if (dbus_ack_q) begin
                        rr_ibus_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Do0 is only valid during ACK; out-of-range accesses never enabled the macro
    assign ibus_rdt   = (ibus_ack_q && !oor_q) ? ram_do : 32'h0;
    assign dbus_rdt   = (dbus_ack_q && !oor_q) ? ram_do : 32'h0;
    assign ibus_ack   = ibus_ack_q;
    assign dbus_ack   = dbus_ack_q;
    assign host_ack   = host_ack_q;
    assign host_rdata = host_rdata_q;
    assign ram_en     = ram_en_q;
    assign ram_a      = ram_a_q;
    assign ram_we     = ram_we_q;
    assign ram_di     = ram_di_q;
endmodule

// File: tb/tb_ram32_access_arbiter.sv
// Bench for ram32_access_arbiter: two instances (round-robin and fixed dbus priority), each with a RAM32 model,
// checked against a word-array memory model and a last-served bookkeeping of the arbitration rules.
module tb_ram32_access_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ibus_cyc, dbus_cyc, dbus_we, host_req, host_we;
    logic [31:0] ibus_adr, dbus_adr, dbus_dat;
    logic [3:0]  dbus_sel;
    logic [6:0]  host_addr;
    logic [7:0]  host_wdata;

    logic [31:0] ibus_rdt, dbus_rdt, ram_di, ram_do;
    logic        ibus_ack, dbus_ack, host_ack, ram_en;
    logic [7:0]  host_rdata;
    logic [4:0]  ram_a;
    logic [3:0]  ram_we;

    logic [31:0] n_ibus_rdt, n_dbus_rdt, n_ram_di, n_ram_do;
    logic        n_ibus_ack, n_dbus_ack, n_host_ack, n_ram_en;
    logic [7:0]  n_host_rdata;
    logic [4:0]  n_ram_a;
    logic [3:0]  n_ram_we;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] ref_mem [32];
    int          last_serv;      // 0: ibus served last, 1: dbus served last
    logic [7:0]  last_host_rd;

    always #5 clk = ~clk;

    ram32_access_arbiter u_dut (
        .clk(clk), .rst_n(rst_n),
        .ibus_cyc(ibus_cyc), .ibus_adr(ibus_adr), .ibus_rdt(ibus_rdt), .ibus_ack(ibus_ack),
        .dbus_cyc(dbus_cyc), .dbus_we(dbus_we), .dbus_adr(dbus_adr), .dbus_dat(dbus_dat),
        .dbus_sel(dbus_sel), .dbus_rdt(dbus_rdt), .dbus_ack(dbus_ack),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_ack(host_ack),
        .ram_en(ram_en), .ram_a(ram_a), .ram_we(ram_we), .ram_di(ram_di), .ram_do(ram_do)
    );

    ram32_access_arbiter #(.RAM_AW(5), .RR_EN(1'b0), .HOST_PRI(1'b1)) u_dut_nr (
        .clk(clk), .rst_n(rst_n),
        .ibus_cyc(ibus_cyc), .ibus_adr(ibus_adr), .ibus_rdt(n_ibus_rdt), .ibus_ack(n_ibus_ack),
        .dbus_cyc(dbus_cyc), .dbus_we(dbus_we), .dbus_adr(dbus_adr), .dbus_dat(dbus_dat),
        .dbus_sel(dbus_sel), .dbus_rdt(n_dbus_rdt), .dbus_ack(n_dbus_ack),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(n_host_rdata), .host_ack(n_host_ack),
        .ram_en(n_ram_en), .ram_a(n_ram_a), .ram_we(n_ram_we), .ram_di(n_ram_di), .ram_do(n_ram_do)
    );

    function automatic logic [31:0] init_word(int i);
        return (32'(i) * 32'h0101_0101) ^ 32'hC3A5_0F1E;
    endfunction

    // RAM32 models: byte-enabled write, synchronous read of the pre-write word
    logic [31:0] mem0 [32];
    logic [31:0] mem1 [32];
    initial begin
        for (int i = 0; i < 32; i++) mem0[i] = init_word(i);
        ram_do = 32'h0;
        forever begin
            @(posedge clk);
            if (ram_en) begin
                for (int b = 0; b < 4; b++)
                    if (ram_we[b]) mem0[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
                ram_do <= mem0[ram_a];
            end
        end
    end
    initial begin
        for (int i = 0; i < 32; i++) mem1[i] = init_word(i);
        n_ram_do = 32'h0;
        forever begin
            @(posedge clk);
            if (n_ram_en) begin
                for (int b = 0; b < 4; b++)
                    if (n_ram_we[b]) mem1[n_ram_a][8*b +: 8] <= n_ram_di[8*b +: 8];
                n_ram_do <= mem1[n_ram_a];
            end
        end
    end

    function automatic logic is_oor(int who, logic [31:0] adr);
        return (who != 2) && (adr[31:7] != 25'h0);
    endfunction

    function automatic logic [31:0] exp_read(int who, logic [31:0] adr);
        logic [31:0] w;
        w = ref_mem[adr[6:2]];
        if (who == 2) return {24'h0, w[8*adr[1:0] +: 8]};
        if (is_oor(who, adr)) return 32'h0;
        return w;
    endfunction

    task automatic ref_write(input int who, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        if (who == 2) begin
            ref_mem[adr[6:2]][8*adr[1:0] +: 8] = dat[7:0];
        end else if (!is_oor(who, adr)) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) ref_mem[adr[6:2]][8*b +: 8] = dat[8*b +: 8];
        end
    endtask

    // Stimulus only: start at an IDLE negedge, raise one request, hold it until its ack, return at an IDLE negedge.
    // who: 0 ibus, 1 dbus, 2 host. lat counts negedges from request to ack (-1 if no ack came).
    task automatic xfer(input int who, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, output int lat, output logic [2:0] ackv, output logic [31:0] rdt,
                        output logic cmd_en, output logic [3:0] cmd_we, output logic [31:0] cmd_di);
        lat = -1; ackv = 3'b000; rdt = 32'h0; cmd_en = 1'b0; cmd_we = 4'h0; cmd_di = 32'h0;
        case (who)
            0: begin ibus_cyc = 1'b1; ibus_adr = adr; end
            1: begin dbus_cyc = 1'b1; dbus_we = we; dbus_adr = adr; dbus_dat = dat; dbus_sel = sel; end
            default: begin host_req = 1'b1; host_we = we; host_addr = adr[6:0]; host_wdata = dat[7:0]; end
        endcase
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) begin cmd_en = ram_en; cmd_we = ram_we; cmd_di = ram_di; end
            ackv = {host_ack, dbus_ack, ibus_ack};
            if (ackv != 3'b000) begin
                lat = n;
                rdt = (who == 0) ? ibus_rdt : (who == 1) ? dbus_rdt : 32'h0;
                break;
            end
        end
        if (ackv[0]) last_serv = 0;
        if (ackv[1]) last_serv = 1;
        ibus_cyc = 1'b0; dbus_cyc = 1'b0; host_req = 1'b0;
        @(negedge clk);
        if (who == 2) rdt = {24'h0, host_rdata};
    endtask

    task automatic test_reset;
        logic [116:0] outs;
        repeat (2) @(negedge clk);
        outs = {ibus_ack, dbus_ack, host_ack, ram_en, ram_we, ram_a, ram_di, ibus_rdt, dbus_rdt, host_rdata};
        vectors++;
        if (outs !== '0) begin miscompares++; $display("FAIL reset_held outs=%h exp 0", outs); end
        rst_n = 1'b1;
        @(negedge clk);
        outs = {ibus_ack, dbus_ack, host_ack, ram_en, ram_we, ram_a, ram_di, ibus_rdt, dbus_rdt, host_rdata};
        vectors++;
        if (outs !== '0) begin miscompares++; $display("FAIL reset_idle outs=%h exp 0", outs); end
    endtask

    task automatic test_round_robin;
        int n, exp_who, got_who;
        ibus_cyc = 1'b1; ibus_adr = 32'h0000_000C;
        dbus_cyc = 1'b1; dbus_we = 1'b0; dbus_adr = 32'h0000_001C; dbus_sel = 4'hF;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!(ibus_ack | dbus_ack) && n < 8);
            exp_who = 1 - last_serv;
            got_who = ibus_ack ? 0 : (dbus_ack ? 1 : -1);
            vectors++;
            if (got_who !== exp_who) begin
                miscompares++; $display("FAIL rr_order k=%0d got=%0d exp=%0d", k, got_who, exp_who);
                break;
            end
            last_serv = got_who;
            vectors++;
            if (n !== ((k == 0) ? 2 : 3)) begin miscompares++; $display("FAIL rr_spacing k=%0d got=%0d", k, n); end
            vectors++;
            if ((got_who == 0 ? ibus_rdt : dbus_rdt) !== exp_read(got_who, got_who == 0 ? ibus_adr : dbus_adr)) begin
                miscompares++; $display("FAIL rr_data k=%0d got=%h", k, got_who == 0 ? ibus_rdt : dbus_rdt);
            end
            vectors++;
            if ({n_ibus_ack, n_dbus_ack} !== 2'b01) begin
                miscompares++; $display("FAIL fixed_pri k=%0d ibus_ack=%b dbus_ack=%b exp 0/1", k, n_ibus_ack, n_dbus_ack);
            end
        end
        ibus_cyc = 1'b0; dbus_cyc = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_host;
        int lat; logic [2:0] ackv; logic [31:0] rdt, di; logic en; logic [3:0] we;
        xfer(2, 1'b1, 32'h06, 32'hA5, 4'h0, lat, ackv, rdt, en, we, di);
        ref_write(2, 32'h06, 32'hA5, 4'h0);
        vectors++;
        if (we !== 4'b0100 || di !== 32'hA5A5_A5A5) begin
            miscompares++; $display("FAIL host_wr_cmd we=%b di=%h exp 0100/a5a5a5a5", we, di);
        end
        vectors++;
        if (lat !== 2 || ackv !== 3'b100) begin miscompares++; $display("FAIL host_wr_ack lat=%0d ack=%b", lat, ackv); end
        xfer(2, 1'b0, 32'h06, 32'h0, 4'h0, lat, ackv, rdt, en, we, di);
        last_host_rd = 8'hA5;
        vectors++;
        if (rdt[7:0] !== 8'hA5 || we !== 4'b0000) begin
            miscompares++; $display("FAIL host_rd rdata=%h we=%b exp a5/0000", rdt[7:0], we);
        end
    endtask

    task automatic test_dbus_then_ibus;
        int lat; logic [2:0] ackv; logic [31:0] rdt, di; logic en; logic [3:0] we;
        xfer(1, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF, lat, ackv, rdt, en, we, di);
        ref_write(1, 32'h10, 32'hFFFF_FFFF, 4'hF);
        xfer(1, 1'b1, 32'h10, 32'h1234_5678, 4'b0011, lat, ackv, rdt, en, we, di);
        ref_write(1, 32'h10, 32'h1234_5678, 4'b0011);
        vectors++;
        if (we !== 4'b0011 || di !== 32'h1234_5678 || lat !== 2 || ackv !== 3'b010) begin
            miscompares++; $display("FAIL dbus_wr we=%b di=%h lat=%0d ack=%b", we, di, lat, ackv);
        end
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, lat, ackv, rdt, en, we, di);
        vectors++;
        if (rdt !== 32'hFFFF_5678 || lat !== 2 || ackv !== 3'b001) begin
            miscompares++; $display("FAIL ibus_rd rdt=%h lat=%0d ack=%b exp ffff5678/2/001", rdt, lat, ackv);
        end
        xfer(1, 1'b1, 32'h10, 32'h0, 4'b0000, lat, ackv, rdt, en, we, di);
        vectors++;
        if (en !== 1'b1 || we !== 4'b0000 || lat !== 2) begin
            miscompares++; $display("FAIL sel0_wr en=%b we=%b lat=%0d exp 1/0000/2", en, we, lat);
        end
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, lat, ackv, rdt, en, we, di);
        vectors++;
        if (rdt !== 32'hFFFF_5678) begin miscompares++; $display("FAIL sel0_unchanged rdt=%h exp ffff5678", rdt); end
    endtask

    task automatic test_out_of_range;
        int lat; logic [2:0] ackv; logic [31:0] rdt, di; logic en; logic [3:0] we;
        xfer(1, 1'b0, 32'h0000_0100, 32'h0, 4'hF, lat, ackv, rdt, en, we, di);
        vectors++;
        if (en !== 1'b0 || lat !== 2 || ackv !== 3'b010 || rdt !== 32'h0) begin
            miscompares++; $display("FAIL oor_dbus en=%b lat=%0d ack=%b rdt=%h", en, lat, ackv, rdt);
        end
        xfer(0, 1'b0, 32'h8000_0004, 32'h0, 4'h0, lat, ackv, rdt, en, we, di);
        vectors++;
        if (en !== 1'b0 || lat !== 2 || ackv !== 3'b001 || rdt !== 32'h0) begin
            miscompares++; $display("FAIL oor_ibus en=%b lat=%0d ack=%b rdt=%h", en, lat, ackv, rdt);
        end
    endtask

    task automatic test_priority;
        int exp_order [3]; int got_order [3]; int at [3]; int k, overlap, who;
        logic [31:0] got;
        logic [7:0] exp_byte;
        k = 0; overlap = 0;
        host_req = 1'b1; host_we = 1'b0; host_addr = 7'($urandom_range(0, 127));
        exp_byte = exp_read(2, {25'h0, host_addr})[7:0];
        ibus_cyc = 1'b1; ibus_adr = {25'h0, 5'($urandom_range(0, 31)), 2'b00};
        dbus_cyc = 1'b1; dbus_we = 1'b0; dbus_adr = {25'h0, 5'($urandom_range(0, 31)), 2'b00};
        exp_order[0] = 2; exp_order[1] = 1 - last_serv; exp_order[2] = last_serv;
        for (int n = 1; n <= 20 && k < 3; n++) begin
            @(negedge clk);
            if ($countones({host_ack, dbus_ack, ibus_ack}) > 1) overlap++;
            if (host_ack | dbus_ack | ibus_ack) begin
                who = host_ack ? 2 : (dbus_ack ? 1 : 0);
                got_order[k] = who; at[k] = n;
                if (who != 2) begin
                    got = (who == 0) ? ibus_rdt : dbus_rdt;
                    vectors++;
                    if (got !== exp_read(who, who == 0 ? ibus_adr : dbus_adr)) begin
                        miscompares++; $display("FAIL prio_data who=%0d got=%h", who, got);
                    end
                    last_serv = who;
                end
                if (who == 0) ibus_cyc = 1'b0;
                if (who == 1) dbus_cyc = 1'b0;
                if (who == 2) host_req = 1'b0;
                k++;
            end
        end
        ibus_cyc = 1'b0; dbus_cyc = 1'b0; host_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (k !== 3) begin
            miscompares++; $display("FAIL prio_count got=%0d exp 3", k);
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (got_order[i] !== exp_order[i]) begin
                    miscompares++; $display("FAIL prio_order slot=%0d got=%0d exp=%0d", i, got_order[i], exp_order[i]);
                end
            end
            vectors++;
            if (at[0] !== 2 || at[1] - at[0] !== 3 || at[2] - at[1] !== 3) begin
                miscompares++; $display("FAIL prio_timing at=%0d,%0d,%0d exp 2,5,8", at[0], at[1], at[2]);
            end
        end
        vectors++;
        if (overlap !== 0) begin miscompares++; $display("FAIL ack_overlap cycles=%0d exp 0", overlap); end
        last_host_rd = exp_byte;
        vectors++;
        if (host_rdata !== exp_byte) begin miscompares++; $display("FAIL prio_host rdata=%h exp %h", host_rdata, exp_byte); end
    endtask

    task automatic test_random;
        int lat, who; logic [2:0] ackv; logic [31:0] rdt, di, adr, dat, exp_rdt; logic en, we_in, oor;
        logic [3:0] we, sel, exp_we;
        for (int i = 0; i < 40; i++) begin
            who   = $urandom_range(0, 2);
            we_in = (who == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            dat   = $urandom;
            sel   = 4'($urandom_range(0, 15));
            if (who == 2) adr = 32'($urandom_range(0, 127));
            else if ($urandom_range(0, 5) == 0) adr = ($urandom | 32'h80) & ~32'h3;
            else adr = {25'h0, 5'($urandom_range(0, 31)), 2'b00};
            oor = is_oor(who, adr);
            exp_we = (who == 2 && we_in) ? (4'b0001 << adr[1:0]) : (who == 1 && we_in && !oor) ? sel : 4'h0;
            exp_rdt = (who == 2 && we_in) ? {24'h0, last_host_rd} : exp_read(who, adr);
            xfer(who, we_in, adr, dat, sel, lat, ackv, rdt, en, we, di);
            if (we_in) ref_write(who, adr, dat, sel);
            else if (who == 2) last_host_rd = exp_rdt[7:0];
            vectors++;
            if (lat !== 2 || ackv !== (3'b001 << who) || en !== !oor || we !== exp_we) begin
                miscompares++;
                $display("FAIL rand_ctl i=%0d who=%0d lat=%0d ack=%b en=%b we=%b exp_we=%b", i, who, lat, ackv, en, we, exp_we);
            end
            if (!we_in || who == 2) begin
                vectors++;
                if (rdt !== exp_rdt) begin
                    miscompares++; $display("FAIL rand_data i=%0d who=%0d adr=%h got=%h exp=%h", i, who, adr, rdt, exp_rdt);
                end
            end
        end
    endtask

    task automatic test_reset_mid_access;
        int lat, stray; logic [2:0] ackv; logic [31:0] rdt, di; logic en; logic [3:0] we;
        logic [116:0] outs;
        stray = 0;
        dbus_cyc = 1'b1; dbus_we = 1'b1; dbus_adr = 32'h24; dbus_dat = ~ref_mem[9]; dbus_sel = 4'hF;
        @(negedge clk);
        vectors++;
        if (ram_en !== 1'b1) begin miscompares++; $display("FAIL rst_cmd ram_en=%b exp 1", ram_en); end
        rst_n = 1'b0;
        #1;
        outs = {ibus_ack, dbus_ack, host_ack, ram_en, ram_we, ram_a, ram_di, ibus_rdt, dbus_rdt, host_rdata};
        vectors++;
        if (outs !== '0) begin miscompares++; $display("FAIL rst_mid outs=%h exp 0", outs); end
        dbus_cyc = 1'b0; dbus_we = 1'b0;
        last_serv = 1; last_host_rd = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (ibus_ack | dbus_ack | host_ack) stray++;
        end
        vectors++;
        if (stray !== 0) begin miscompares++; $display("FAIL rst_no_ack stray=%0d exp 0", stray); end
        xfer(1, 1'b0, 32'h24, 32'h0, 4'hF, lat, ackv, rdt, en, we, di);
        vectors++;
        if (lat !== 2 || ackv !== 3'b010 || rdt !== ref_mem[9]) begin
            miscompares++; $display("FAIL rst_after lat=%0d ack=%b rdt=%h exp 2/010/%h", lat, ackv, rdt, ref_mem[9]);
        end
    endtask

    initial begin
        ibus_cyc = 1'b0; ibus_adr = 32'h0; dbus_cyc = 1'b0; dbus_we = 1'b0; dbus_adr = 32'h0;
        dbus_dat = 32'h0; dbus_sel = 4'h0; host_req = 1'b0; host_we = 1'b0; host_addr = 7'h0; host_wdata = 8'h0;
        for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);
        last_serv = 1; last_host_rd = 8'h00;
        test_reset;
        test_round_robin;
        test_host;
        test_dbus_then_ibus;
        test_out_of_range;
        test_priority;
        test_random;
        test_reset_mid_access;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end
endmodule
